// File: rtl/axi_regfile_slave_if.sv
// rtl/axi_regfile_slave_if.sv - AXI-style five-channel bus bundle for axi_regfile_slave.
// Optional W_STRB lane enables exist only when AXI_REGFILE_WSTRB_EN is defined.
interface axi_regfile_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] read_address;
  logic              AR_VALID;
  logic              AR_READY;
  logic [DATA_W-1:0] data_read;
  logic [1:0]        R_RESP;
  logic              R_VALID;
  logic              R_READY;
  logic [ADDR_W-1:0] write_address;
  logic              AW_VALID;
  logic              AW_READY;
  logic [DATA_W-1:0] data_write;
  logic              W_VALID;
  logic              W_READY;
  logic [1:0]        B_RESP;
  logic              B_VALID;
  logic              B_READY;
`ifdef AXI_REGFILE_WSTRB_EN
  logic [DATA_W/8-1:0] W_STRB;
`endif

  modport slave (
    input  read_address, AR_VALID, R_READY,
    input  write_address, AW_VALID, data_write, W_VALID, B_READY,
`ifdef AXI_REGFILE_WSTRB_EN
    input  W_STRB,
`endif
    output AR_READY, data_read, R_RESP, R_VALID,
    output AW_READY, W_READY, B_RESP, B_VALID
  );

  modport master (
    output read_address, AR_VALID, R_READY,
    output write_address, AW_VALID, data_write, W_VALID, B_READY,
`ifdef AXI_REGFILE_WSTRB_EN
    output W_STRB,
`endif
    input  AR_READY, data_read, R_RESP, R_VALID,
    input  AW_READY, W_READY, B_RESP, B_VALID
  );
endinterface

// File: rtl/axi_regfile_slave.sv
// rtl/axi_regfile_slave.sv - DEPTH-entry register file behind independent AXI-style read/write engines.
// Byte-strobed writes are enabled by defining AXI_REGFILE_WSTRB_EN.
module axi_regfile_slave #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic clk,
  input  logic rst,
  axi_regfile_slave_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

  r_state_t r_state;
  w_state_t w_state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;

  logic              ar_hs, aw_hs, w_hs;
  logic              commit, commit_ok, rd_ok;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
`ifdef AXI_REGFILE_WSTRB_EN
  logic [DATA_W/8-1:0] w_strb_q;
  logic [DATA_W/8-1:0] commit_strb;
`endif

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  // The write lands on the edge where the second of AW/W handshakes; the
  // half already captured comes from the holding registers.
  always_comb begin
    ar_hs       = bus.AR_VALID && bus.AR_READY;
    aw_hs       = bus.AW_VALID && bus.AW_READY;
    w_hs        = bus.W_VALID && bus.W_READY;
    commit      = 1'b0;
    commit_addr = bus.write_address;
    commit_data = bus.data_write;
`ifdef AXI_REGFILE_WSTRB_EN
    commit_strb = bus.W_STRB;
`endif
    case (w_state)
      W_IDLE: commit = aw_hs && w_hs;
      W_ADDR: begin
        commit      = w_hs;
        commit_addr = aw_addr_q;
      end
      W_DATA: begin
        commit      = aw_hs;
        commit_data = w_data_q;
`ifdef AXI_REGFILE_WSTRB_EN
        commit_strb = w_strb_q;
`endif
      end
      default: commit = 1'b0;
    endcase
    commit_ok = in_range(commit_addr);
    rd_ok     = in_range(bus.read_address);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && commit_ok) begin
`ifdef AXI_REGFILE_WSTRB_EN
      for (int b = 0; b < DATA_W/8; b++)
        if (commit_strb[b]) mem[commit_addr[IDX_W-1:0]][b*8 +: 8] <= commit_data[b*8 +: 8];
`else
      mem[commit_addr[IDX_W-1:0]] <= commit_data;
`endif
    end
  end

  // Read engine: mem is sampled before any same-edge write lands, so a
  // colliding read returns the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= R_IDLE;
      bus.AR_READY  <= 1'b0;
      bus.R_VALID   <= 1'b0;
      bus.R_RESP    <= RESP_OKAY;
      bus.data_read <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            bus.data_read <= rd_ok ? mem[bus.read_address[IDX_W-1:0]] : '0;
            bus.R_RESP    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            bus.R_VALID   <= 1'b1;
            bus.AR_READY  <= 1'b0;
            r_state       <= R_DATA;
          end else begin
            bus.AR_READY  <= 1'b1;
          end
        end
        default: begin
          if (bus.R_VALID && bus.R_READY) begin
            bus.R_VALID  <= 1'b0;
            bus.AR_READY <= 1'b1;
            r_state      <= R_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state      <= W_IDLE;
      bus.AW_READY <= 1'b0;
      bus.W_READY  <= 1'b0;
      bus.B_VALID  <= 1'b0;
      bus.B_RESP   <= RESP_OKAY;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
`ifdef AXI_REGFILE_WSTRB_EN
      w_strb_q     <= '0;
`endif
    end else if (commit) begin
      bus.B_VALID  <= 1'b1;
      bus.B_RESP   <= commit_ok ? RESP_OKAY : RESP_SLVERR;
      bus.AW_READY <= 1'b0;
      bus.W_READY  <= 1'b0;
      w_state      <= W_RESP;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr_q    <= bus.write_address;
            bus.AW_READY <= 1'b0;
            w_state      <= W_ADDR;
          end else if (w_hs) begin
            w_data_q     <= bus.data_write;
`ifdef AXI_REGFILE_WSTRB_EN
            w_strb_q     <= bus.W_STRB;
`endif
            bus.W_READY  <= 1'b0;
            w_state      <= W_DATA;
          end else begin
            bus.AW_READY <= 1'b1;
            bus.W_READY  <= 1'b1;
          end
        end
        W_RESP: begin
          if (bus.B_VALID && bus.B_READY) begin
            bus.B_VALID  <= 1'b0;
            bus.AW_READY <= 1'b1;
            bus.W_READY  <= 1'b1;
            w_state      <= W_IDLE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_regfile_slave.sv
// tb/tb_axi_regfile_slave.sv - randomized self-checking bench for axi_regfile_slave.
// Define AXI_REGFILE_WSTRB_EN to exercise the byte-strobe build with 32-bit data.
module tb_axi_regfile_slave;
  localparam int ADDR_W = 4;
`ifdef AXI_REGFILE_WSTRB_EN
  localparam int DATA_W = 32;
`else
  localparam int DATA_W = 8;
`endif
  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [DATA_W-1:0] model [DEPTH];

  axi_regfile_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_regfile_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int bp);
    logic [DATA_W-1:0] exp_d;
    logic [1:0]        exp_r;
    int n;
    bus.read_address = a;
    bus.AR_VALID = 1'b1;
    n = 0;
    while (!bus.AR_READY && n < 20) begin step(); n++; end
    check("ar_ready_wait", 64'(bus.AR_READY), 64'd1);
    exp_d = (int'(a) < DEPTH) ? model[int'(a)] : '0;
    exp_r = (int'(a) < DEPTH) ? 2'b00 : 2'b10;
    step();
    bus.AR_VALID = 1'b0;
    check("r_valid", 64'(bus.R_VALID), 64'd1);
    check("ar_ready_busy", 64'(bus.AR_READY), 64'd0);
    check("r_data", 64'(bus.data_read), 64'(exp_d));
    check("r_resp", 64'(bus.R_RESP), 64'(exp_r));
    for (int i = 0; i < bp; i++) begin
      step();
      check("r_hold_valid", 64'(bus.R_VALID), 64'd1);
      check("r_hold_data", 64'(bus.data_read), 64'(exp_d));
      check("r_hold_ar", 64'(bus.AR_READY), 64'd0);
    end
    bus.R_READY = 1'b1;
    step();
    bus.R_READY = 1'b0;
    check("r_done", 64'(bus.R_VALID), 64'd0);
    check("ar_ready_back", 64'(bus.AR_READY), 64'd1);
  endtask

  // mode 0: AW and W together, 1: AW first, 2: W first; gap = idle cycles between.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [STRB_W-1:0] s, input int mode, input int gap, input int bp);
    logic [1:0] exp_r;
    int n;
    bus.write_address = a;
    bus.data_write = d;
`ifdef AXI_REGFILE_WSTRB_EN
    bus.W_STRB = s;
`endif
    exp_r = (int'(a) < DEPTH) ? 2'b00 : 2'b10;
    n = 0;
    if (mode == 0) begin
      bus.AW_VALID = 1'b1;
      bus.W_VALID = 1'b1;
      while (!(bus.AW_READY && bus.W_READY) && n < 20) begin step(); n++; end
      check("aw_w_ready_wait", 64'(bus.AW_READY && bus.W_READY), 64'd1);
      step();
      bus.AW_VALID = 1'b0;
      bus.W_VALID = 1'b0;
    end else if (mode == 1) begin
      bus.AW_VALID = 1'b1;
      while (!bus.AW_READY && n < 20) begin step(); n++; end
      check("aw_ready_wait", 64'(bus.AW_READY), 64'd1);
      step();
      bus.AW_VALID = 1'b0;
      check("aw_ready_drop", 64'(bus.AW_READY), 64'd0);
      for (int i = 0; i < gap; i++) begin
        step();
        check("w_ready_waiting", 64'(bus.W_READY), 64'd1);
      end
      check("w_ready_pre", 64'(bus.W_READY), 64'd1);
      check("b_idle_pre", 64'(bus.B_VALID), 64'd0);
      bus.W_VALID = 1'b1;
      step();
      bus.W_VALID = 1'b0;
    end else begin
      bus.W_VALID = 1'b1;
      while (!bus.W_READY && n < 20) begin step(); n++; end
      check("w_ready_wait", 64'(bus.W_READY), 64'd1);
      step();
      bus.W_VALID = 1'b0;
      check("w_ready_drop", 64'(bus.W_READY), 64'd0);
      for (int i = 0; i < gap; i++) begin
        step();
        check("aw_ready_waiting", 64'(bus.AW_READY), 64'd1);
      end
      check("aw_ready_pre", 64'(bus.AW_READY), 64'd1);
      check("b_idle_pre", 64'(bus.B_VALID), 64'd0);
      bus.AW_VALID = 1'b1;
      step();
      bus.AW_VALID = 1'b0;
    end
    if (int'(a) < DEPTH)
      for (int b = 0; b < STRB_W; b++)
        if (s[b]) model[int'(a)][b*8 +: 8] = d[b*8 +: 8];
    check("b_valid", 64'(bus.B_VALID), 64'd1);
    check("b_resp", 64'(bus.B_RESP), 64'(exp_r));
    check("aw_ready_busy", 64'(bus.AW_READY), 64'd0);
    check("w_ready_busy", 64'(bus.W_READY), 64'd0);
    for (int i = 0; i < bp; i++) begin
      step();
      check("b_hold_valid", 64'(bus.B_VALID), 64'd1);
      check("b_hold_resp", 64'(bus.B_RESP), 64'(exp_r));
      check("b_hold_aw", 64'(bus.AW_READY), 64'd0);
    end
    bus.B_READY = 1'b1;
    step();
    bus.B_READY = 1'b0;
    check("b_done", 64'(bus.B_VALID), 64'd0);
    check("aw_ready_back", 64'(bus.AW_READY), 64'd1);
    check("w_ready_back", 64'(bus.W_READY), 64'd1);
  endtask

  task automatic check_all_clear(input string tag);
    check({tag, "_ar_ready"}, 64'(bus.AR_READY), 64'd0);
    check({tag, "_aw_ready"}, 64'(bus.AW_READY), 64'd0);
    check({tag, "_w_ready"}, 64'(bus.W_READY), 64'd0);
    check({tag, "_r_valid"}, 64'(bus.R_VALID), 64'd0);
    check({tag, "_b_valid"}, 64'(bus.B_VALID), 64'd0);
    check({tag, "_data_read"}, 64'(bus.data_read), 64'd0);
    check({tag, "_r_resp"}, 64'(bus.R_RESP), 64'd0);
    check({tag, "_b_resp"}, 64'(bus.B_RESP), 64'd0);
  endtask

  logic [STRB_W-1:0] full_strb;

  initial begin
    full_strb = '1;
    bus.read_address = '0;
    bus.AR_VALID = 1'b0;
    bus.R_READY = 1'b0;
    bus.write_address = '0;
    bus.AW_VALID = 1'b0;
    bus.data_write = '0;
    bus.W_VALID = 1'b0;
    bus.B_READY = 1'b0;
`ifdef AXI_REGFILE_WSTRB_EN
    bus.W_STRB = '0;
`endif
    clear_model();

    repeat (10) @(posedge clk);
    #1;
    check_all_clear("reset");
    rst = 1'b1;
    step();
    check("ar_ready_after_reset", 64'(bus.AR_READY), 64'd1);
    check("aw_ready_after_reset", 64'(bus.AW_READY), 64'd1);
    check("w_ready_after_reset", 64'(bus.W_READY), 64'd1);
    do_read(4'd9, 0);

    do_write(4'd5, DATA_W'(8'hAA), full_strb, 0, 0, 0);
    do_read(4'd5, 0);
    do_write(4'd2, DATA_W'(8'h3C), full_strb, 2, 3, 0);
    do_read(4'd2, 0);
    do_write(4'd6, DATA_W'(8'h71), full_strb, 1, 2, 4);
    do_read(4'd6, 4);

    do_write(4'd14, DATA_W'(8'h5E), full_strb, 0, 0, 0);
    do_read(4'd14, 0);
    do_write(4'd12, DATA_W'(8'h11), full_strb, 2, 1, 1);
    do_read(4'd12, 1);

    // Read and write of the same register handshake on the same edge.
    fork
      do_write(4'd5, DATA_W'(8'h96), full_strb, 0, 0, 0);
      do_read(4'd5, 0);
    join
    do_read(4'd5, 0);

`ifdef AXI_REGFILE_WSTRB_EN
    do_write(4'd1, 32'h11223344, 4'hF, 0, 0, 0);
    do_write(4'd1, 32'hAABBCCDD, 4'b0101, 2, 1, 0);
    do_read(4'd1, 0);
    check("strb_word", 64'(bus.data_read), 64'h11BB33DD);
    do_write(4'd1, 32'hFFFFFFFF, 4'h0, 1, 0, 0);
    do_read(4'd1, 0);
`endif

    for (int it = 0; it < 60; it++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic [STRB_W-1:0] s;
      a = ADDR_W'($urandom_range(0, 15));
      d = DATA_W'($urandom);
`ifdef AXI_REGFILE_WSTRB_EN
      s = STRB_W'($urandom);
`else
      s = full_strb;
`endif
      case ($urandom_range(0, 2))
        0: do_read(a, $urandom_range(0, 3));
        1: do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
        default: fork
          do_write(a, d, s, 0, 0, $urandom_range(0, 2));
          do_read(a, $urandom_range(0, 2));
        join
      endcase
    end
    for (int i = 0; i < 16; i++) do_read(ADDR_W'(i), 0);

    // Reset while a write waits for data in W_ADDR.
    do_write(4'd3, DATA_W'(8'h5A), full_strb, 0, 0, 0);
    bus.write_address = 4'd3;
    bus.AW_VALID = 1'b1;
    step();
    bus.AW_VALID = 1'b0;
    check("w_addr_state_aw", 64'(bus.AW_READY), 64'd0);
    #2 rst = 1'b0;
    #1 check_all_clear("rst_w_addr");
    clear_model();
    #2 rst = 1'b1;
    step();
    check("aw_ready_after_rst2", 64'(bus.AW_READY), 64'd1);
    do_read(4'd3, 0);

    // Reset while read data is pending.
    do_write(4'd7, DATA_W'(8'hC3), full_strb, 0, 0, 0);
    bus.read_address = 4'd7;
    bus.AR_VALID = 1'b1;
    step();
    bus.AR_VALID = 1'b0;
    check("r_pending", 64'(bus.R_VALID), 64'd1);
    #2 rst = 1'b0;
    #1 check_all_clear("rst_r_data");
    clear_model();
    #2 rst = 1'b1;
    step();
    do_read(4'd7, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_regfile_slave.md
Name: axi_regfile_slave

Overview:
- Parametrised successor to the current read-only AXI slave. Implements all five channels (AR, R, AW, W, B) in front of a DEPTH-entry register file, with response codes and independent read and write engines.
- Sits on the master/slave interconnect and pairs directly with the existing AXI master's signal set.
- Single outstanding transaction per direction.

Parameters:
- ADDR_W, 4, address width (word address).
- DATA_W, 8, data width in bits; must be a multiple of 8 when WSTRB_EN is defined.
- DEPTH, 16, number of registers; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  system clock; one clock, all logic on rising edge.
- rst  input  1  reset; asynchronous and active-low.
- read_address  input  ADDR_W  AR channel address.
- AR_VALID  input  1  AR valid.
- AR_READY  output  1  AR ready.
- data_read  output  DATA_W  R channel data.
- R_RESP  output  2  read response: 00 OKAY, 10 SLVERR.
- R_VALID  output  1  R valid.
- R_READY  input  1  R ready.
- write_address  input  ADDR_W  AW channel address.
- AW_VALID  input  1  AW valid.
- AW_READY  output  1  AW ready.
- data_write  input  DATA_W  W channel data.
- W_VALID  input  1  W valid.
- W_READY  output  1  W ready.
- B_RESP  output  2  write response: 00 OKAY, 10 SLVERR.
- B_VALID  output  1  B valid.
- B_READY  input  1  B ready.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs go to 0: READYs, VALIDs, data_read, R_RESP, B_RESP.
  - All registers clear to 0; both FSMs go to IDLE.
  - Reset mid-transaction aborts the transaction; a pending write is not committed.
- All outputs are registered. READYs rise on the first clk edge after rst releases.
- Handshake: transfer occurs on a rising edge where VALID && READY. Once VALID is asserted, the slave holds data_read/R_RESP and B_RESP stable until the matching handshake.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: AR_READY=1. On AR handshake at edge N: sample mem[read_address] into data_read, set R_RESP, go to R_DATA. AR_READY=0 and R_VALID=1 from edge N.
  - Latency from AR handshake to R_VALID is 1 cycle.
  - R_DATA: hold until R_READY. On R handshake: R_VALID=0, AR_READY=1, return to R_IDLE. Back-to-back reads are therefore spaced 2 cycles minimum.
- Write FSM, states W_IDLE, W_ADDR, W_DATA, W_RESP:
  - W_IDLE: AW_READY=1, W_READY=1. AW and W may arrive in either order or together.
  - AW alone: latch address, AW_READY=0, go to W_ADDR (waiting for data).
  - W alone: latch data, W_READY=0, go to W_DATA (waiting for address).
  - Both in the same edge, or the second one arriving: commit the write at that edge, set B_RESP, B_VALID=1, both READYs=0, go to W_RESP.
  - W_RESP: on B handshake, B_VALID=0, both READYs=1, return to W_IDLE.
- Address decode:
  - Index = address; valid when address < DEPTH.
  - Out-of-range read: data_read=0, R_RESP=10.
  - Out-of-range write: no register changes, B_RESP=10.
- Read/write collision: if an AR handshake and a write commit to the same index occur on the same edge, the read returns the old value. The new value is visible to any later read.
- The read and write engines are fully independent; neither blocks the other.

Optional Feature:
- Macro: AXI_REGFILE_WSTRB_EN.
- Defined:
  - Adds input W_STRB, width DATA_W/8, sampled and latched with W.
  - Byte lane i of the register is written only when W_STRB[i]=1.
  - W_STRB=0 with a valid address still returns OKAY and changes nothing.
- Undefined:
  - Port W_STRB is absent.
  - Every write updates the full word.

Test Plan:
- Reset: hold rst=0 for 10 cycles -> all outputs 0. Release -> next edge AR_READY=AW_READY=W_READY=1. Read any address -> 00, OKAY.
- AW=5 and W=8'hAA presented in the same cycle -> B_VALID the next cycle with B_RESP=00. Then AR=5 -> R_VALID 1 cycle after the handshake, data_read=8'hAA, R_RESP=00.
- W=8'h3C presented 3 cycles before AW=2 -> W_READY drops after the W handshake while AW_READY stays 1. Write commits at the AW handshake; a read of 2 returns 8'h3C.
- Backpressure: R_READY held low 4 cycles, B_READY held low 4 cycles -> R_VALID/data_read and B_VALID/B_RESP stay stable, AR_READY and AW_READY stay 0 until each handshake.
- DEPTH=12: write address 14 -> B_RESP=10; read address 14 -> data 0, R_RESP=10. Registers 0..11 unchanged.
- rst pulsed low while in W_ADDR, and separately while R_VALID=1 -> outputs clear immediately, and a read of the targeted address after reset returns 0.
- With AXI_REGFILE_WSTRB_EN, DATA_W=32: write 32'h11223344 with strobe 4'hF, then 32'hAABBCCDD with strobe 4'b0101 -> a read returns 32'h11BB33DD.
